md4_round_sequencer: RTL

Multi-cycle MD4 compression controller that computes one 32-bit MD4 step per clock. A single shared step datapath, rotl(a + f(b,c,d) + X[k] + K, s), is reused for all 16×ROUNDS steps. The block sequences the round function, message-word index, shift amount and round constant, then optionally adds the chaining input back in (feed-forward). It replaces a fully unrolled combinational round chain where area matters, and exposes a start/done handshake to the hashing top level.

---
 rtl/md4_round_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/md4_round_sequencer.sv
// md4_round_sequencer
// Iterative MD4 compression core: one shared step datapath executes one
// MD4 step per clock across ROUNDS rounds (fixed order F, G, H), with an
// optional feed-forward add of the chaining input at the end.
// ROUNDS must be 1, 2 or 3; the step counter is sized for at most 48 steps.
module md4_round_sequencer #(
  parameter int ROUNDS       = 3,
  parameter bit FEED_FORWARD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  output logic         busy,
  output logic         done,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] x,
  output logic [31:0]  out_a,
  output logic [31:0]  out_b,
  output logic [31:0]  out_c,
  output logic [31:0]  out_d,
  output logic [5:0]   step
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [5:0] LAST_STEP = 6'(16 * ROUNDS - 1);

  localparam logic [31:0] K_ROUND0 = 32'h0000_0000;
  localparam logic [31:0] K_ROUND1 = 32'h5A82_7999;
  localparam logic [31:0] K_ROUND2 = 32'h6ED9_EBA1;

  logic [1:0]   state_q;
  logic [5:0]   step_q;
  logic         done_q;

  logic [31:0]  reg_a;
  logic [31:0]  reg_b;
  logic [31:0]  reg_c;
  logic [31:0]  reg_d;

  logic [31:0]  iv_a;
  logic [31:0]  iv_b;
  logic [31:0]  iv_c;
  logic [31:0]  iv_d;

  logic [511:0] x_q;

  logic [1:0]   round_idx;
  logic [3:0]   j_idx;
  logic [31:0]  f_val;
  logic [31:0]  k_const;
  logic [3:0]   k_idx;
  logic [4:0]   s_amt;
  logic [31:0]  x_word;
  logic [31:0]  step_sum;
  logic [31:0]  step_new;

  logic         accept;
  logic         last_step;
  logic         finish_raw;
  logic         finish_ff;

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
    return (v << s) | (v >> (6'd32 - {1'b0, s}));
  endfunction

  assign round_idx  = step_q[5:4];
  assign j_idx      = step_q[3:0];
  assign accept     = (state_q == ST_IDLE) && start;
  assign last_step  = (step_q == LAST_STEP);
  assign finish_raw = (state_q == ST_RUN) && last_step && !FEED_FORWARD;
  assign finish_ff  = (state_q == ST_FIN);

  // Round-dependent decode: boolean function, constant, message index and shift
  always_comb begin
    f_val   = '0;
    k_const = K_ROUND0;
    k_idx   = j_idx;
    s_amt   = 5'd3;
    case (round_idx)
      2'd0: begin
        f_val   = (reg_b & reg_c) | (~reg_b & reg_d);
        k_const = K_ROUND0;
        k_idx   = j_idx;
        case (j_idx[1:0])
          2'd0:    s_amt = 5'd3;
          2'd1:    s_amt = 5'd7;
          2'd2:    s_amt = 5'd11;
          default: s_amt = 5'd19;
        endcase
      end
      2'd1: begin
        f_val   = (reg_b & reg_c) | (reg_b & reg_d) | (reg_c & reg_d);
        k_const = K_ROUND1;
        k_idx   = {j_idx[1:0], j_idx[3:2]};
        case (j_idx[1:0])
          2'd0:    s_amt = 5'd3;
          2'd1:    s_amt = 5'd5;
          2'd2:    s_amt = 5'd9;
          default: s_amt = 5'd13;
        endcase
      end
      default: begin
        f_val   = reg_b ^ reg_c ^ reg_d;
        k_const = K_ROUND2;
        k_idx   = {j_idx[0], j_idx[1], j_idx[2], j_idx[3]};
        case (j_idx[1:0])
          2'd0:    s_amt = 5'd3;
          2'd1:    s_amt = 5'd9;
          2'd2:    s_amt = 5'd11;
          default: s_amt = 5'd15;
        endcase
      end
    endcase
  end

  // Shared step datapath: rotl(a + f + X[k] + K, s)
  always_comb begin
    x_word   = x_q[{k_idx, 5'd0} +: 32];
    step_sum = reg_a + f_val + x_word + k_const;
    step_new = rotl32(step_sum, s_amt);
  end

  // Control FSM: accept, step counting, completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            step_q  <= '0;
          end
        end
        ST_RUN: begin
          if (last_step) begin
            step_q <= '0;
            if (FEED_FORWARD) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end else begin
            step_q <= step_q + 6'd1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= '0;
        end
      endcase
    end
  end

  // Working registers and latched block inputs; rotate (A,B,C,D) <- (D,new,B,C) each step
  always_ff @(posedge clk) begin
    if (accept) begin
      reg_a <= a_in;
      reg_b <= b_in;
      reg_c <= c_in;
      reg_d <= d_in;
      iv_a  <= a_in;
      iv_b  <= b_in;
      iv_c  <= c_in;
      iv_d  <= d_in;
      x_q   <= x;
    end else if (state_q == ST_RUN) begin
      reg_a <= reg_d;
      reg_b <= step_new;
      reg_c <= reg_b;
      reg_d <= reg_c;
    end
  end

  // Result registers load only at completion and hold until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a <= '0;
      out_b <= '0;
      out_c <= '0;
      out_d <= '0;
    end else if (finish_ff) begin
      out_a <= reg_a + iv_a;
      out_b <= reg_b + iv_b;
      out_c <= reg_c + iv_c;
      out_d <= reg_d + iv_d;
    end else if (finish_raw) begin
      out_a <= reg_d;
      out_b <= step_new;
      out_c <= reg_b;
      out_d <= reg_c;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign ready = ~busy;
  assign done  = done_q;
  assign step  = (state_q == ST_RUN) ? step_q : 6'd0;

endmodule
